msrv32_fetch_pc: RTL and testbench

MSRV32_FETCH_PC -- requirements
Module: msrv32_fetch_pc

---
 rtl/msrv32_fetch_pc.sv | 134 +++++++++++++
 tb/tb_msrv32_fetch_pc.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_fetch_pc.sv
// ============================================================================
// Module  : msrv32_fetch_pc
// Brief   : RV32 fetch-address / PC generator with bus stall and redirect
//           buffering. Optional compressed-ISA support via MSRV32_RVC_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module msrv32_fetch_pc #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [1:0]        pc_src_in,
    input  logic [XLEN-1:0]   epc_in,
    input  logic [XLEN-1:0]   trap_address_in,
    input  logic              branch_taken_in,
    input  logic [XLEN-1:1]   iaddr_in,
    input  logic              ahb_ready_in,
    input  logic              instr_len16_in,
    output logic [XLEN-1:0]   iaddr_out,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   pc_plus_4_out,
    output logic [XLEN-1:0]   pc_mux_out,
    output logic              misaligned_instr_logic_out,
    output logic              redirect_pending_out
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

    localparam logic [1:0] c_SRC_BOOT = 2'b00;
    localparam logic [1:0] c_SRC_EPC  = 2'b01;
    localparam logic [1:0] c_SRC_TRAP = 2'b10;

    state_t            r_state;
    logic [XLEN-1:0]   r_pend_target;

    logic [XLEN-1:0]   w_step;
    logic [XLEN-1:0]   w_seq_target;
    logic [XLEN-1:0]   w_br_target;
    logic [XLEN-1:0]   w_eff_target;
    logic              w_branch;
    logic              w_redirect;

`ifdef MSRV32_RVC_EN
    assign w_step = instr_len16_in ? XLEN'(2) : XLEN'(4);
    // Bit 0 of the branch target is always zero, so halfword alignment holds.
    assign misaligned_instr_logic_out = 1'b0;
`else
    logic w_unused_len16;
    assign w_unused_len16 = instr_len16_in;
    assign w_step = XLEN'(4);
    assign misaligned_instr_logic_out = w_branch & w_br_target[1];
`endif

    assign w_seq_target  = iaddr_out + w_step;
    assign pc_plus_4_out = pc_out + w_step;
    assign w_br_target   = {iaddr_in, 1'b0};
    assign w_branch      = (pc_src_in == 2'b11) && branch_taken_in;
    assign w_redirect    = (pc_src_in != 2'b11) || branch_taken_in;

    always_comb begin
        pc_mux_out = w_seq_target;
        case (pc_src_in)
            c_SRC_BOOT: pc_mux_out = RESET_VECTOR;
            c_SRC_EPC:  pc_mux_out = epc_in;
            c_SRC_TRAP: pc_mux_out = trap_address_in;
            default:    pc_mux_out = branch_taken_in ? w_br_target : w_seq_target;
        endcase
    end

    // A misaligned branch target is dropped in favour of the fall-through address.
    assign w_eff_target = misaligned_instr_logic_out ? w_seq_target : pc_mux_out;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state              <= ST_RUN;
            iaddr_out            <= RESET_VECTOR;
            pc_out               <= RESET_VECTOR;
            r_pend_target        <= '0;
            redirect_pending_out <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ahb_ready_in) begin
                        iaddr_out <= w_eff_target;
                        pc_out    <= iaddr_out;
                    end else if (w_redirect) begin
                        r_pend_target        <= w_eff_target;
                        r_state              <= ST_PEND;
                        redirect_pending_out <= 1'b1;
                    end else begin
                        r_state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (w_redirect) begin
                        r_pend_target        <= w_eff_target;
                        r_state              <= ST_PEND;
                        redirect_pending_out <= 1'b1;
                    end else if (ahb_ready_in) begin
                        iaddr_out <= w_seq_target;
                        pc_out    <= iaddr_out;
                        r_state   <= ST_RUN;
                    end
                end
                ST_PEND: begin
                    if (w_redirect) begin
                        r_pend_target <= w_eff_target;
                    end
                    // A redirect arriving with ready bypasses the stale pending target.
                    if (ahb_ready_in) begin
                        iaddr_out            <= w_redirect ? w_eff_target : r_pend_target;
                        pc_out               <= iaddr_out;
                        r_state              <= ST_RUN;
                        redirect_pending_out <= 1'b0;
                    end
                end
                default: begin
                    r_state              <= ST_RUN;
                    redirect_pending_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_msrv32_fetch_pc.sv
// ============================================================================
// Module  : tb_msrv32_fetch_pc
// Brief   : Directed scenarios plus randomized run against a reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msrv32_fetch_pc;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [1:0]  pc_src_in;
    logic [31:0] epc_in;
    logic [31:0] trap_address_in;
    logic        branch_taken_in;
    logic [31:1] iaddr_in;
    logic        ahb_ready_in;
    logic        instr_len16_in;
    logic [31:0] iaddr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic [31:0] pc_mux_out;
    logic        misaligned_instr_logic_out;
    logic        redirect_pending_out;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    msrv32_fetch_pc dut (
        .clk_in                     (clk),
        .rst_in                     (rst_in),
        .pc_src_in                  (pc_src_in),
        .epc_in                     (epc_in),
        .trap_address_in            (trap_address_in),
        .branch_taken_in            (branch_taken_in),
        .iaddr_in                   (iaddr_in),
        .ahb_ready_in               (ahb_ready_in),
        .instr_len16_in             (instr_len16_in),
        .iaddr_out                  (iaddr_out),
        .pc_out                     (pc_out),
        .pc_plus_4_out              (pc_plus_4_out),
        .pc_mux_out                 (pc_mux_out),
        .misaligned_instr_logic_out (misaligned_instr_logic_out),
        .redirect_pending_out       (redirect_pending_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] src, input logic taken, input logic [31:0] target,
                         input logic ready);
        pc_src_in       = src;
        branch_taken_in = taken;
        iaddr_in        = target[31:1];
        ahb_ready_in    = ready;
    endtask

    task automatic test_reset();
        rst_in          = 1'b0;
        epc_in          = '0;
        trap_address_in = '0;
        instr_len16_in  = 1'b0;
        drive(2'b11, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        tests_run++;
        if (iaddr_out !== 32'h0 || pc_out !== 32'h0 || redirect_pending_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: iaddr=%h pc=%h pend=%b, want 0 0 0",
                     iaddr_out, pc_out, redirect_pending_out);
        end
        rst_in = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_run++;
            if (iaddr_out !== 32'(4 * i) || pc_out !== 32'(4 * (i - 1))) begin
                tests_failed++;
                $display("FAIL sequential[%0d]: iaddr=%h pc=%h, want %h %h",
                         i, iaddr_out, pc_out, 32'(4 * i), 32'(4 * (i - 1)));
            end
        end
        tests_run++;
        if (pc_plus_4_out !== 32'h10) begin
            tests_failed++;
            $display("FAIL link_addr: pc_plus_4=%h, want 00000010", pc_plus_4_out);
        end
    endtask

    task automatic test_stall();
        drive(2'b11, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (iaddr_out !== 32'h10 || pc_out !== 32'h0C || redirect_pending_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: iaddr=%h pc=%h pend=%b, want 10 0c 0",
                         i, iaddr_out, pc_out, redirect_pending_out);
            end
        end
        ahb_ready_in = 1'b1;
        tick();
        tests_run++;
        if (iaddr_out !== 32'h14 || pc_out !== 32'h10) begin
            tests_failed++;
            $display("FAIL stall_release: iaddr=%h pc=%h, want 14 10", iaddr_out, pc_out);
        end
    endtask

    task automatic test_trap_pend();
        trap_address_in = 32'h100;
        drive(2'b10, 1'b0, 32'h0, 1'b0);
        #1;
        tests_run++;
        if (pc_mux_out !== 32'h100) begin
            tests_failed++;
            $display("FAIL trap_mux: pc_mux=%h, want 00000100", pc_mux_out);
        end
        tick();
        tests_run++;
        if (redirect_pending_out !== 1'b1 || iaddr_out !== 32'h14) begin
            tests_failed++;
            $display("FAIL trap_pend: pend=%b iaddr=%h, want 1 14", redirect_pending_out, iaddr_out);
        end
        drive(2'b11, 1'b0, 32'h0, 1'b0);
        tick();
        drive(2'b11, 1'b0, 32'h0, 1'b1);
        tick();
        tests_run++;
        if (iaddr_out !== 32'h100 || pc_out !== 32'h14 || redirect_pending_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL trap_release: iaddr=%h pc=%h pend=%b, want 100 14 0",
                     iaddr_out, pc_out, redirect_pending_out);
        end
    endtask

    task automatic test_newest_wins();
        drive(2'b11, 1'b1, 32'h200, 1'b0);
        tick();
        epc_in = 32'h300;
        drive(2'b01, 1'b0, 32'h0, 1'b0);
        tick();
        tests_run++;
        if (redirect_pending_out !== 1'b1 || iaddr_out !== 32'h100) begin
            tests_failed++;
            $display("FAIL newest_pend: pend=%b iaddr=%h, want 1 100", redirect_pending_out, iaddr_out);
        end
        drive(2'b11, 1'b0, 32'h0, 1'b1);
        tick();
        tests_run++;
        if (iaddr_out !== 32'h300 || pc_out !== 32'h100) begin
            tests_failed++;
            $display("FAIL newest_wins: iaddr=%h pc=%h, want 300 100", iaddr_out, pc_out);
        end
    endtask

    task automatic test_misaligned();
        logic        exp_mis;
        logic [31:0] exp_iaddr;
        logic [31:0] exp_link;
`ifdef MSRV32_RVC_EN
        exp_mis   = 1'b0;
        exp_iaddr = 32'h22;
        exp_link  = 32'h302;
`else
        exp_mis   = 1'b1;
        exp_iaddr = 32'h304;
        exp_link  = 32'h304;
`endif
        instr_len16_in = 1'b1;
        drive(2'b11, 1'b1, 32'h22, 1'b1);
        #1;
        tests_run++;
        if (misaligned_instr_logic_out !== exp_mis || pc_mux_out !== 32'h22) begin
            tests_failed++;
            $display("FAIL misaligned_flag: mis=%b mux=%h, want %b 00000022",
                     misaligned_instr_logic_out, pc_mux_out, exp_mis);
        end
        tick();
        tests_run++;
        if (iaddr_out !== exp_iaddr || pc_out !== 32'h300) begin
            tests_failed++;
            $display("FAIL misaligned_load: iaddr=%h pc=%h, want %h 300", iaddr_out, pc_out, exp_iaddr);
        end
        tests_run++;
        if (pc_plus_4_out !== exp_link) begin
            tests_failed++;
            $display("FAIL step_len16: pc_plus_4=%h, want %h", pc_plus_4_out, exp_link);
        end
        instr_len16_in = 1'b0;
    endtask

    task automatic test_wrap_and_async_reset();
        trap_address_in = 32'hFFFF_FFFC;
        drive(2'b10, 1'b0, 32'h0, 1'b1);
        tick();
        drive(2'b11, 1'b0, 32'h0, 1'b1);
        tick();
        tests_run++;
        if (iaddr_out !== 32'h0 || pc_out !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap: iaddr=%h pc=%h, want 0 fffffffc", iaddr_out, pc_out);
        end
        epc_in = 32'h40;
        drive(2'b01, 1'b0, 32'h0, 1'b0);
        tick();
        drive(2'b11, 1'b0, 32'h0, 1'b0);
        #1;
        rst_in = 1'b0;
        #1;
        tests_run++;
        if (iaddr_out !== 32'h0 || pc_out !== 32'h0 || redirect_pending_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: iaddr=%h pc=%h pend=%b, want 0 0 0",
                     iaddr_out, pc_out, redirect_pending_out);
        end
        tick();
        ahb_ready_in = 1'b1;
        rst_in       = 1'b1;
        tick();
        tests_run++;
        if (iaddr_out !== 32'h4 || pc_out !== 32'h0 || redirect_pending_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_discard: iaddr=%h pc=%h pend=%b, want 4 0 0",
                     iaddr_out, pc_out, redirect_pending_out);
        end
    endtask

    // Reference model: the accepted-address stream, one optional buffered redirect,
    // and a flag recording that the bus refused a plain sequential fetch.
    logic [31:0] m_iaddr, m_pc, m_ptgt;
    logic        m_has_pend, m_stalled;

    task automatic test_random();
        logic [31:0] step, seq, br, tgt, raw;
        logic        mis, redir, ready;
        m_iaddr    = 32'h4;
        m_pc       = 32'h0;
        m_has_pend = 1'b0;
        m_stalled  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            epc_in          = $urandom;
            trap_address_in = $urandom;
            instr_len16_in  = 1'($urandom_range(0, 1));
            drive(($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 9) < 3), $urandom, ($urandom_range(0, 3) != 0));
`ifdef MSRV32_RVC_EN
            step = instr_len16_in ? 32'd2 : 32'd4;
            mis  = 1'b0;
`else
            step = 32'd4;
            mis  = 1'b0;
`endif
            seq   = m_iaddr + step;
            br    = {iaddr_in, 1'b0};
`ifndef MSRV32_RVC_EN
            mis   = (pc_src_in == 2'b11) && branch_taken_in && br[1];
`endif
            case (pc_src_in)
                2'b00:   raw = 32'h0;
                2'b01:   raw = epc_in;
                2'b10:   raw = trap_address_in;
                default: raw = branch_taken_in ? br : seq;
            endcase
            tgt   = mis ? seq : raw;
            redir = (pc_src_in != 2'b11) || branch_taken_in;
            ready = ahb_ready_in;
            #1;
            tests_run++;
            if (pc_mux_out !== raw || misaligned_instr_logic_out !== mis ||
                pc_plus_4_out !== m_pc + step || redirect_pending_out !== m_has_pend) begin
                tests_failed++;
                $display("FAIL rand_comb[%0d]: mux=%h mis=%b link=%h pend=%b, want %h %b %h %b",
                         n, pc_mux_out, misaligned_instr_logic_out, pc_plus_4_out,
                         redirect_pending_out, raw, mis, m_pc + step, m_has_pend);
            end
            if (m_has_pend) begin
                if (redir) m_ptgt = tgt;
                if (ready) begin
                    m_pc = m_iaddr; m_iaddr = m_ptgt; m_has_pend = 1'b0;
                end
            end else if (redir && (m_stalled || !ready)) begin
                m_ptgt = tgt; m_has_pend = 1'b1; m_stalled = 1'b0;
            end else if (ready) begin
                m_pc = m_iaddr; m_iaddr = m_stalled ? seq : tgt; m_stalled = 1'b0;
            end else begin
                m_stalled = 1'b1;
            end
            tick();
            tests_run++;
            if (iaddr_out !== m_iaddr || pc_out !== m_pc) begin
                tests_failed++;
                $display("FAIL rand_seq[%0d]: iaddr=%h pc=%h, want %h %h",
                         n, iaddr_out, pc_out, m_iaddr, m_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_trap_pend();
        test_newest_wins();
        test_misaligned();
        test_wrap_and_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
